alarm_beeper: RTL

- Audio output stage of the alarm/stopwatch design; it drives the board's AUD_PWM pin.
- On a one-cycle alarm trigger from the timekeeping core, it plays a fixed pattern of BEEP_NUM tone bursts separated by silences.
- Each burst is a square-wave tone whose high phase is amplitude-modulated by a PWM carrier set by a volume input.
- Stop (user button) aborts the pattern at any time.

---
 rtl/alarm_beeper.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alarm_beeper.sv
// Alarm audio stage: plays BEEP_NUM tone bursts separated by silences on trigger.
// Each burst's tone-high phase is PWM-modulated by the volume latched at trigger.
module alarm_beeper #(
   parameter int TONE_DIV     = 50000,
   parameter int BEEP_ON_CYC  = 20000000,
   parameter int BEEP_OFF_CYC = 10000000,
   parameter int BEEP_NUM     = 4,
   parameter int PWM_BITS     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                trigger,
   input  logic                stop,
   input  logic [PWM_BITS-1:0] volume,
   output logic                aud_pwm,
   output logic                busy,
   output logic                done,
   output logic [3:0]          beep_idx
);
   localparam int PH_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TN_W   = $clog2(TONE_DIV + 1);
   localparam logic [PH_W-1:0] ON_LAST   = PH_W'(BEEP_ON_CYC - 1);
   localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(BEEP_OFF_CYC - 1);
   localparam logic [TN_W-1:0] TONE_LAST = TN_W'(TONE_DIV - 1);
   localparam logic [3:0]      IDX_LAST  = 4'(BEEP_NUM - 1);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

   state_t              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [TN_W-1:0]     tone_q, tone_d;
   logic                tone_ph_q, tone_ph_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [PWM_BITS-1:0] vol_q, vol_d;
   logic [3:0]          idx_q, idx_d;
   logic                aud_q, aud_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         tone_q    <= '0;
         tone_ph_q <= 1'b0;
         pwm_q     <= '0;
         vol_q     <= '0;
         idx_q     <= '0;
         aud_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         tone_q    <= tone_d;
         tone_ph_q <= tone_ph_d;
         pwm_q     <= pwm_d;
         vol_q     <= vol_d;
         idx_q     <= idx_d;
         aud_q     <= aud_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      tone_d    = tone_q;
      tone_ph_d = tone_ph_q;
      vol_d     = vol_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      pwm_d     = (state_q != S_IDLE) ? pwm_q + 1'b1 : '0;
      // Output is built from pre-edge state, so it lags the state by one cycle.
      aud_d     = (state_q == S_ON) & tone_ph_q & (pwm_q < vol_q);

      case (state_q)
         S_IDLE: begin
            if (trigger && !stop) begin
               state_d   = S_ON;
               vol_d     = volume;
               idx_d     = '0;
               phase_d   = '0;
               tone_d    = '0;
               tone_ph_d = 1'b1;
               pwm_d     = '0;
            end
         end
         S_ON: begin
            if (tone_q == TONE_LAST) begin
               tone_d    = '0;
               tone_ph_d = ~tone_ph_q;
            end else begin
               tone_d = tone_q + 1'b1;
            end
            if (stop) begin
               state_d = S_IDLE;
               idx_d   = '0;
               phase_d = '0;
            end else if (phase_q == ON_LAST) begin
               phase_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_OFF;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_OFF: begin
            if (stop) begin
               state_d = S_IDLE;
               idx_d   = '0;
               phase_d = '0;
            end else if (phase_q == OFF_LAST) begin
               state_d   = S_ON;
               phase_d   = '0;
               idx_d     = idx_q + 1'b1;
               tone_d    = '0;
               tone_ph_d = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign aud_pwm  = aud_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign beep_idx = idx_q;
endmodule
